// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter over eight single-bit sources driving
// an 8:1 data mux. A grant lasts until its source drops its request or until
// HOLD_MAX transfers have been accepted downstream. On release the arbiter
// moves directly to the next requester, skipping the released source.
module mux8_rr_arbiter #(
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic [7:0] in,
   input  logic       ready,
   output logic [2:0] sel,
   output logic [7:0] grant,
   output logic       valid,
   output logic       y,
   output logic       busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic [7:0] grant_q, grant_d;
   logic [7:0] count_q, count_d;
   logic [2:0] last_q, last_d;

   logic       transfer;
   logic       release_now;
   logic [3:0] pick_idle;
   logic [3:0] pick_release;
   logic [7:0] masked_req;

   // The search starts at ptr+1 and wraps round to ptr itself. The loop runs
   // from the farthest candidate to the nearest so the nearest one wins.
   // Result bit 3 flags that some request was found.
   function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] ptr);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'd0;
      for (int i = 8; i >= 1; i--) begin
         idx = ptr + 3'(i);
         if (r[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   assign busy  = (state_q == GRANT);
   assign valid = busy && req[sel_q];
   assign y     = valid ? in[sel_q] : 1'b0;
   assign sel   = sel_q;
   assign grant = grant_q;

   assign transfer    = valid && ready;
   assign release_now = !req[sel_q] || (transfer && (count_q == 8'(HOLD_MAX - 1)));
   assign masked_req  = req & ~(8'b1 << sel_q);
   assign pick_idle    = rr_pick(req, last_q);
   assign pick_release = rr_pick(masked_req, sel_q);

   // This block handles next-state arbitration: grant from IDLE, or hold,
   // count, and release from GRANT. A release hands the grant straight to
   // the next requester when one is waiting.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      count_d = count_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            grant_d = 8'd0;
            if (pick_idle[3]) begin
               state_d = GRANT;
               sel_d   = pick_idle[2:0];
               grant_d = 8'b1 << pick_idle[2:0];
               count_d = 8'd0;
            end
         end
         GRANT: begin
            if (release_now) begin
               last_d = sel_q;
               if (pick_release[3]) begin
                  sel_d   = pick_release[2:0];
                  grant_d = 8'b1 << pick_release[2:0];
                  count_d = 8'd0;
               end else begin
                  state_d = IDLE;
                  grant_d = 8'd0;
               end
            end else if (transfer) begin
               count_d = count_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = 8'd0;
         end
      endcase
   end

   // The state register. Reset points the search pointer at source 7, so
   // the first search after reset begins at source 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= 3'd0;
         grant_q <= 8'd0;
         count_q <= 8'd0;
         last_q  <= 3'd7;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         count_q <= count_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed testbench for mux8_rr_arbiter with HOLD_MAX = 4. Inputs change on
// the falling edge, and outputs are sampled on the falling edge after each
// rising edge.
module tb_mux8_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] in;
   logic       ready;
   logic [2:0] sel;
   logic [7:0] grant;
   logic       valid;
   logic       y;
   logic       busy;

   int n_checks;
   int n_fail;

   mux8_rr_arbiter #(.HOLD_MAX(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .in    (in),
      .ready (ready),
      .sel   (sel),
      .grant (grant),
      .valid (valid),
      .y     (y),
      .busy  (busy)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Holds reset across two clock edges with all inputs quiet, then releases it on a falling edge.
   task automatic do_reset();
      rst_n = 1'b0;
      req   = 8'd0;
      in    = 8'd0;
      ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Checks reset values while inputs are active, and that arbitration
   // begins at the first edge after release.
   task automatic test_reset();
      rst_n = 1'b0; req = 8'hFF; in = 8'hFF; ready = 1'b1;
      @(negedge clk);
      n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL reset_grant got %h exp 00", grant); end
      n_checks++; if (sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel got %0d exp 0", sel); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid); end
      n_checks++; if (y !== 1'b0) begin n_fail++; $display("FAIL reset_y got %b exp 0", y); end
      rst_n = 1'b1;
      #1;
      n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL post_release_grant got %h exp 00", grant); end
      @(negedge clk);
      n_checks++; if (grant !== 8'h01) begin n_fail++; $display("FAIL first_arb_grant got %h exp 01", grant); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_arb_busy got %b exp 1", busy); end
   endtask

   // Verifies the full rotation with all sources requesting: each source
   // holds for four cycles and hands over back to back.
   task automatic test_back_to_back();
      logic [7:0] pat;
      int s;
      pat = 8'b1010_0101;
      do_reset();
      req = 8'hFF; ready = 1'b1; in = pat;
      for (int g = 0; g < 9; g++) begin
         s = g % 8;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++; if (grant !== (8'b1 << s)) begin n_fail++; $display("FAIL rot_grant g=%0d c=%0d got %h exp %h", g, c, grant, 8'b1 << s); end
            n_checks++; if (sel !== 3'(s)) begin n_fail++; $display("FAIL rot_sel g=%0d c=%0d got %0d exp %0d", g, c, sel, s); end
            n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL rot_valid g=%0d c=%0d got %b exp 1", g, c, valid); end
            n_checks++; if (y !== pat[s]) begin n_fail++; $display("FAIL rot_y g=%0d c=%0d got %b exp %b", g, c, y, pat[s]); end
         end
      end
   endtask

   // A single source is released after its hold limit, passes through IDLE, and is granted again.
   task automatic test_single_source();
      do_reset();
      in = 8'b1010_0101; req = 8'h08; ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks++; if (grant !== 8'h08) begin n_fail++; $display("FAIL single_grant c=%0d got %h exp 08", c, grant); end
         n_checks++; if (sel !== 3'd3) begin n_fail++; $display("FAIL single_sel c=%0d got %0d exp 3", c, sel); end
         n_checks++; if (y !== 1'b0) begin n_fail++; $display("FAIL single_y c=%0d got %b exp 0", c, y); end
      end
      @(negedge clk);
      n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL single_idle_grant got %h exp 00", grant); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy got %b exp 0", busy); end
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_valid got %b exp 0", valid); end
      @(negedge clk);
      n_checks++; if (grant !== 8'h08) begin n_fail++; $display("FAIL single_regrant got %h exp 08", grant); end
      n_checks++; if (sel !== 3'd3) begin n_fail++; $display("FAIL single_regrant_sel got %0d exp 3", sel); end
   endtask

   // While ready is low, the grant holds and no transfers are counted. After
   // ready rises, exactly four transfers occur before release.
   task automatic test_stall();
      do_reset();
      req = 8'h01; ready = 1'b0; in = 8'h00;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_checks++; if (grant !== 8'h01) begin n_fail++; $display("FAIL stall_grant i=%0d got %h exp 01", i, grant); end
         n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid i=%0d got %b exp 1", i, valid); end
         if (i == 9) ready = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if (grant !== 8'h01) begin n_fail++; $display("FAIL stall_xfer_grant i=%0d got %h exp 01", i, grant); end
      end
      @(negedge clk);
      n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL stall_release got %h exp 00", grant); end
   endtask

   // The granted source 5 drops its request. No transfer occurs that cycle,
   // and the search wraps past 7 to source 0.
   task automatic test_drop();
      do_reset();
      req = 8'h20; ready = 1'b1; in = 8'hFF;
      @(negedge clk);
      n_checks++; if (grant !== 8'h20) begin n_fail++; $display("FAIL drop_grant5 got %h exp 20", grant); end
      req = 8'h05;
      #1;
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid got %b exp 0", valid); end
      n_checks++; if (y !== 1'b0) begin n_fail++; $display("FAIL drop_y got %b exp 0", y); end
      @(negedge clk);
      n_checks++; if (grant !== 8'h01) begin n_fail++; $display("FAIL drop_next_grant got %h exp 01", grant); end
      n_checks++; if (sel !== 3'd0) begin n_fail++; $display("FAIL drop_next_sel got %0d exp 0", sel); end
   endtask

   // Reset mid-grant clears the outputs at once. After release, source 6 wins
   // first and gets a full four-cycle hold.
   task automatic test_reset_mid();
      do_reset();
      req = 8'h40; ready = 1'b1; in = 8'hFF;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (grant !== 8'h40) begin n_fail++; $display("FAIL mid_pre_grant got %h exp 40", grant); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL mid_rst_grant got %h exp 00", grant); end
      n_checks++; if (sel !== 3'd0) begin n_fail++; $display("FAIL mid_rst_sel got %0d exp 0", sel); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
      n_checks++; if (y !== 1'b0) begin n_fail++; $display("FAIL mid_rst_y got %b exp 0", y); end
      req = 8'hC0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks++; if (grant !== 8'h40) begin n_fail++; $display("FAIL mid_after_grant c=%0d got %h exp 40", c, grant); end
         n_checks++; if (sel !== 3'd6) begin n_fail++; $display("FAIL mid_after_sel c=%0d got %0d exp 6", c, sel); end
      end
      @(negedge clk);
      n_checks++; if (grant !== 8'h80) begin n_fail++; $display("FAIL mid_next_grant got %h exp 80", grant); end
   endtask

   // Runs every scenario in order and prints the summary line.
   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0; req = 8'd0; in = 8'd0; ready = 1'b0;
      test_reset();
      test_back_to_back();
      test_single_source();
      test_stall();
      test_drop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux8_rr_arbiter.md
MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001 The block SHALL have parameter: HOLD_MAX, 4, maximum accepted transfers per grant; legal range 1..255.
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port: req  input  8  per-source request; bit i = source i.
REQ-005 The block SHALL have port: in  input  8  per-source data bit; bit i = source i data.
REQ-006 The block SHALL have port: ready  input  1  downstream accepts y this cycle.
REQ-007 The block SHALL have port: sel  output  3  registered select of the 8:1 data mux.
REQ-008 The block SHALL have port: grant  output  8  registered one-hot grant; all-zero when idle.
REQ-009 The block SHALL have port: valid  output  1  y carries granted source data this cycle.
REQ-010 The block SHALL have port: y  output  1  muxed data; equals in[sel] when valid, else 0.
REQ-011 The block SHALL have port: busy  output  1  high while in state GRANT.

Function
REQ-012 The FSM SHALL have two states: IDLE and GRANT.
REQ-013 Internal round-robin pointer last (3 bits) SHALL hold the index of the most recently released source.
REQ-014 Arbitration SHALL select the first asserted req bit, searching last+1, last+2, ..., last (mod 8, wrap 7->0).
REQ-015 IDLE, req != 0 at a rising edge: go to GRANT; load sel with the winner; grant = one-hot(winner); count = 0.
REQ-016 IDLE, req == 0: stay in IDLE; sel holds its value; grant = 0.
REQ-017 Request-to-grant latency SHALL be exactly 1 cycle: req sampled at edge N, grant visible after edge N.
REQ-018 valid SHALL be combinational: (state == GRANT) && req[sel].
REQ-019 y SHALL be combinational: in[sel] when valid, else 0.
REQ-020 A transfer SHALL occur in any cycle with valid && ready.
REQ-021 count (8 bits) SHALL increment by 1 on each transfer and reset to 0 on every new grant.
REQ-022 GRANT release condition: req[sel] == 0 at the edge, or a transfer occurs with count == HOLD_MAX-1.
REQ-023 On release: last <= sel; re-arbitrate in the same edge over req with bit sel masked off.
REQ-024 Release with any other request pending: go directly to the new winner with no idle cycle (back-to-back grant).
REQ-025 Release with no other request pending: go to IDLE; grant = 0.
REQ-026 The re-arbitration mask SHALL prevent the just-released source from winning at that edge even if it is the only requester.
REQ-027 A released source that still requests SHALL be re-granted via IDLE one cycle later, with no starvation of others.
REQ-028 GRANT, no release condition: hold sel/grant; ready low stalls without changing count.
REQ-029 Simultaneous req[sel] falling and ready high in one cycle: valid = 0, so no transfer; release per REQ-022.
REQ-030 No source SHALL hold the grant for more than HOLD_MAX transfers.
REQ-031 Any requesting source SHALL be granted within 7 other grants.

Reset
REQ-032 rst_n low SHALL asynchronously force state = IDLE, sel = 0, grant = 0, busy = 0, count = 0, last = 7 (first search starts at source 0).
REQ-033 While rst_n is low, valid = 0 and y = 0 regardless of other inputs.
REQ-034 Reset assertion mid-transfer SHALL abort the grant immediately with no transfer counted.
REQ-035 After rst_n rises, the first arbitration SHALL take place at the next rising edge.

Verification
REQ-036 Reset then req=8'hFF, ready=1, HOLD_MAX=4 -> grants 0,1,2,...,7,0, each 4 cycles long with valid=1, back-to-back, sel following the grant.
REQ-037 in=8'b1010_0101, req=8'h08 (source 3) held, ready=1 -> one cycle later sel=3, grant=8'h08, y=0; after 4 transfers release to IDLE, then re-grant source 3.
REQ-038 req=8'h01, ready=0 for 10 cycles, then 1 -> grant held on source 0 throughout, count stays 0 until ready rises, then 4 transfers.
REQ-039 Granted source 5 drops req while ready=1 -> valid=0 that cycle, no transfer counted, next grant goes to the next pending source above 5 (wrapping).
REQ-040 rst_n pulsed low mid-grant on source 6 -> grant=0, sel=0, busy=0 immediately; after release, req=8'hC0 -> source 6 granted first.
